// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: bundle of requester-side and adder-side signals of mp_add_seq.
//   req/a*/b*/ci*/len*  -> requests from the two clients
//   gnt/busy/done/...   <- sequencer status and results
//   add_a/add_b/add_ci  <- operands to the shared registered adder
//   add_s/add_co        -> adder results
// slave  : the sequencer side.
// master : the environment (requesters plus adder).
interface mp_add_seq_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned NW = 4,
  parameter int unsigned LW = 3
);
  logic [1:0]      req;
  logic [W*NW-1:0] a0, b0, a1, b1;
  logic            ci0, ci1;
  logic [LW-1:0]   len0, len1;
  logic [1:0]      gnt;
  logic            busy;
  logic            done;
  logic            done_id;
  logic [W*NW-1:0] sum;
  logic            cout;
  logic [W-1:0]    add_a, add_b, add_s;
  logic            add_ci, add_co;

  modport slave (
    input  req, a0, b0, ci0, len0, a1, b1, ci1, len1, add_s, add_co,
    output gnt, busy, done, done_id, sum, cout, add_a, add_b, add_ci
  );

  modport master (
    output req, a0, b0, ci0, len0, a1, b1, ci1, len1, add_s, add_co,
    input  gnt, busy, done, done_id, sum, cout, add_a, add_b, add_ci
  );
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer sharing one registered W-bit adder
// between two round-robin requesters. Operands are walked LSW first with each
// word's carry-out chained into the next word's carry-in.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mp_add_seq_if.slave (requests, results, adder operands/results)
module mp_add_seq #(
  parameter int unsigned W       = 16,
  parameter int unsigned NW      = 4,
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned LW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mp_add_seq_if.slave   bus
);

  localparam int unsigned DW = W * NW;
  localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic [DW-1:0]   r_a, r_b, r_acc, r_sum;
  logic [DW-1:0]   w_a_n, w_b_n, w_acc_n, w_sum_n;
  logic [IW-1:0]   r_idx, r_last, w_idx_n, w_last_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_carry, r_owner, r_prio, r_busy, r_done, r_done_id, r_cout;
  logic            w_carry_n, w_owner_n, w_prio_n, w_busy_n, w_done_n, w_done_id_n, w_cout_n;
  logic [W-1:0]    r_add_a, r_add_b, w_add_a_n, w_add_b_n;
  logic            r_add_ci, w_add_ci_n;
  logic [1:0]      w_gnt;

  // Request selection and operand muxing
  logic            w_win;
  logic [DW-1:0]   w_a_sel, w_b_sel, w_merge;
  logic            w_ci_sel;
  logic [LW-1:0]   w_len_sel, w_len_eff;
  logic [IW-1:0]   w_idx_inc;

  // With both requesting, the requester not granted last time wins
  assign w_win     = (bus.req == 2'b11) ? r_prio : bus.req[1];
  assign w_a_sel   = w_win ? bus.a1   : bus.a0;
  assign w_b_sel   = w_win ? bus.b1   : bus.b0;
  assign w_ci_sel  = w_win ? bus.ci1  : bus.ci0;
  assign w_len_sel = w_win ? bus.len1 : bus.len0;
  assign w_len_eff = ((w_len_sel == '0) || (w_len_sel > LW'(NW))) ? LW'(NW) : w_len_sel;
  assign w_idx_inc = r_idx + IW'(1);

  // Accumulator with the adder's current word dropped into slot idx
  assign w_merge = (r_acc & ~(DW'({W{1'b1}}) << (W * r_idx)))
                 | (DW'(bus.add_s) << (W * r_idx));

  // Next-state and datapath update
  always_comb begin
    w_state_n   = r_state;
    w_gnt       = 2'b00;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_acc_n     = r_acc;
    w_sum_n     = r_sum;
    w_idx_n     = r_idx;
    w_last_n    = r_last;
    w_cnt_n     = r_cnt;
    w_carry_n   = r_carry;
    w_owner_n   = r_owner;
    w_prio_n    = r_prio;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_done_id_n = r_done_id;
    w_cout_n    = r_cout;
    w_add_a_n   = r_add_a;
    w_add_b_n   = r_add_b;
    w_add_ci_n  = r_add_ci;

    case (r_state)
      S_IDLE: begin
        // Grant is combinational so operands are captured in the grant cycle
        if (rst_n && (bus.req != 2'b00)) begin
          w_gnt       = w_win ? 2'b10 : 2'b01;
          w_a_n       = w_a_sel;
          w_b_n       = w_b_sel;
          w_carry_n   = w_ci_sel;
          w_last_n    = IW'(w_len_eff - LW'(1));
          w_owner_n   = w_win;
          w_prio_n    = ~w_win;
          w_acc_n     = '0;
          w_idx_n     = '0;
          w_add_a_n   = w_a_sel[W-1:0];
          w_add_b_n   = w_b_sel[W-1:0];
          w_add_ci_n  = w_ci_sel;
          w_busy_n    = 1'b1;
          w_state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_n   = CW'(ADD_LAT);
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_acc_n   = w_merge;
          w_carry_n = bus.add_co;
          if (r_idx == r_last) begin
            w_sum_n     = w_merge;
            w_cout_n    = bus.add_co;
            w_done_id_n = r_owner;
            w_done_n    = 1'b1;
            w_state_n   = S_DONE;
          end else begin
            // Next word's operands go out as we re-enter ISSUE
            w_idx_n    = w_idx_inc;
            w_add_a_n  = W'(r_a >> (W * w_idx_inc));
            w_add_b_n  = W'(r_b >> (W * w_idx_inc));
            w_add_ci_n = bus.add_co;
            w_state_n  = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_busy_n   = 1'b0;
        w_add_a_n  = '0;
        w_add_b_n  = '0;
        w_add_ci_n = 1'b0;
        w_state_n  = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_owner   <= 1'b0;
      r_prio    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_cout    <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_ci  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_acc     <= w_acc_n;
      r_sum     <= w_sum_n;
      r_idx     <= w_idx_n;
      r_last    <= w_last_n;
      r_cnt     <= w_cnt_n;
      r_carry   <= w_carry_n;
      r_owner   <= w_owner_n;
      r_prio    <= w_prio_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_done_id <= w_done_id_n;
      r_cout    <= w_cout_n;
      r_add_a   <= w_add_a_n;
      r_add_b   <= w_add_b_n;
      r_add_ci  <= w_add_ci_n;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.sum     = r_sum;
  assign bus.cout    = r_cout;
  assign bus.add_a   = r_add_a;
  assign bus.add_b   = r_add_b;
  assign bus.add_ci  = r_add_ci;

endmodule
